// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-enable-qualified h/v counters with registered
// sync, data-enable, coordinate and line/frame start outputs.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   XW       = 10,
  parameter int   YW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  input  logic          en,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  localparam logic [31:0] H_TOTAL  = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [31:0] V_TOTAL  = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [31:0] H_ACT_C  = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT_C  = 32'(V_ACTIVE);
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] H_LAST   = H_TOTAL - 32'd1;
  localparam logic [31:0] V_LAST   = V_TOTAL - 32'd1;

  logic [XW-1:0] h_cnt_r;
  logic [YW-1:0] v_cnt_r;
  logic [31:0]   h_ext_s;
  logic [31:0]   v_ext_s;
  logic          h_wrap_s;
  logic          v_wrap_s;
  logic          de_s;
  logic          hs_act_s;
  logic          vs_act_s;

  assign h_ext_s = 32'(h_cnt_r);
  assign v_ext_s = 32'(v_cnt_r);

  // Decode timing regions from the current (pre-increment) counts.
  always_comb begin
    h_wrap_s = 1'b0;
    v_wrap_s = 1'b0;
    de_s     = 1'b0;
    hs_act_s = 1'b0;
    vs_act_s = 1'b0;
    h_wrap_s = (h_ext_s == H_LAST);
    v_wrap_s = (v_ext_s == V_LAST);
    de_s     = (h_ext_s < H_ACT_C) && (v_ext_s < V_ACT_C);
    hs_act_s = (h_ext_s >= HS_START) && (h_ext_s < HS_END);
    vs_act_s = (v_ext_s >= VS_START) && (v_ext_s < VS_END);
  end

  // Raster position counters; en low parks them at the origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= {XW{1'b0}};
      v_cnt_r <= {YW{1'b0}};
    end else if (!en) begin
      h_cnt_r <= {XW{1'b0}};
      v_cnt_r <= {YW{1'b0}};
    end else if (pix_ce) begin
      if (h_wrap_s) begin
        h_cnt_r <= {XW{1'b0}};
        v_cnt_r <= v_wrap_s ? {YW{1'b0}} : (v_cnt_r + YW'(1));
      end else begin
        h_cnt_r <= h_cnt_r + XW'(1);
        v_cnt_r <= v_cnt_r;
      end
    end else begin
      h_cnt_r <= h_cnt_r;
      v_cnt_r <= v_cnt_r;
    end
  end

  // Registered outputs: levels hold between pixel enables, strobes last one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      de_o          <= 1'b0;
      x_o           <= {XW{1'b0}};
      y_o           <= {YW{1'b0}};
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (!en) begin
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      de_o          <= 1'b0;
      x_o           <= {XW{1'b0}};
      y_o           <= {YW{1'b0}};
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (pix_ce) begin
      hsync_o       <= hs_act_s ? HS_POL : ~HS_POL;
      vsync_o       <= vs_act_s ? VS_POL : ~VS_POL;
      de_o          <= de_s;
      x_o           <= h_cnt_r;
      y_o           <= v_cnt_r;
      line_start_o  <= (h_cnt_r == {XW{1'b0}});
      frame_start_o <= (h_cnt_r == {XW{1'b0}}) && (v_cnt_r == {YW{1'b0}});
    end else begin
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen in a small 8x6 mode with mixed sync
// polarities: vector table, reference-model scoreboard and corner sequences.
module tb_vga_timing_gen;

  localparam int   HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int   VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam logic HSP = 1'b1;
  localparam logic VSP = 1'b0;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [3:0] x;
    logic [3:0] y;
    logic       ls;
    logic       fs;
  } out_t;

  typedef struct {
    logic ce;
    logic en;
    out_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic       en = 1'b0;
  logic       hsync_o, vsync_o, de_o, line_start_o, frame_start_o;
  logic [3:0] x_o, y_o;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mh = 0;
  int   mv = 0;
  out_t mexp;
  out_t sbq[$];
  out_t rst_val;
  vec_t tbl[14];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .XW(4), .YW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .en(en),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .x_o(x_o), .y_o(y_o),
    .line_start_o(line_start_o), .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(logic hs, logic vs, logic de, int x, int y, logic ls, logic fs);
    out_t o;
    o.hs = hs; o.vs = vs; o.de = de; o.x = 4'(x); o.y = 4'(y); o.ls = ls; o.fs = fs;
    return o;
  endfunction

  function automatic vec_t mkv(logic ce, logic e, out_t o);
    vec_t v;
    v.ce = ce; v.en = e; v.exp = o;
    return v;
  endfunction

  function automatic out_t get_act();
    return mk(hsync_o, vsync_o, de_o, int'(x_o), int'(y_o), line_start_o, frame_start_o);
  endfunction

  task automatic check(input string nm, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference raster model: predicts the outputs after the coming clock edge.
  task automatic model_push(input logic ce, input logic e);
    if (!e) begin
      mexp = rst_val;
      mh = 0;
      mv = 0;
    end else if (ce) begin
      mexp.x  = 4'(mh);
      mexp.y  = 4'(mv);
      mexp.de = (mh < HA) && (mv < VA);
      mexp.hs = (mh >= HA + HF && mh < HA + HF + HS) ? HSP : ~HSP;
      mexp.vs = (mv >= VA + VF && mv < VA + VF + VS) ? VSP : ~VSP;
      mexp.ls = (mh == 0);
      mexp.fs = (mh == 0) && (mv == 0);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end else begin
      mexp.ls = 1'b0;
      mexp.fs = 1'b0;
    end
    sbq.push_back(mexp);
  endtask

  task automatic step(input logic ce, input logic e);
    out_t exp;
    pix_ce = ce;
    en = e;
    model_push(ce, e);
    @(posedge clk);
    #1;
    cyc++;
    if (sbq.size() == 0) begin
      check_int("sb_empty", 0, 1);
    end else begin
      exp = sbq.pop_front();
      check("sb", get_act(), exp);
    end
  endtask

  initial begin
    int nfs, nls, nde, nvs, nhs, guard;
    rst_val = mk(~HSP, ~VSP, 1'b0, 0, 0, 1'b0, 1'b0);
    mexp = rst_val;

    tbl[0]  = mkv(1'b1, 1'b1, mk(1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1));
    tbl[1]  = mkv(1'b0, 1'b1, mk(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0));
    tbl[2]  = mkv(1'b1, 1'b1, mk(1'b0, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0));
    tbl[3]  = mkv(1'b1, 1'b1, mk(1'b0, 1'b1, 1'b1, 2, 0, 1'b0, 1'b0));
    tbl[4]  = mkv(1'b1, 1'b1, mk(1'b0, 1'b1, 1'b1, 3, 0, 1'b0, 1'b0));
    tbl[5]  = mkv(1'b1, 1'b1, mk(1'b0, 1'b1, 1'b0, 4, 0, 1'b0, 1'b0));
    tbl[6]  = mkv(1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0));
    tbl[7]  = mkv(1'b0, 1'b1, mk(1'b1, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0));
    tbl[8]  = mkv(1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 6, 0, 1'b0, 1'b0));
    tbl[9]  = mkv(1'b1, 1'b1, mk(1'b0, 1'b1, 1'b0, 7, 0, 1'b0, 1'b0));
    tbl[10] = mkv(1'b1, 1'b1, mk(1'b0, 1'b1, 1'b1, 0, 1, 1'b1, 1'b0));
    tbl[11] = mkv(1'b1, 1'b0, mk(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0));
    tbl[12] = mkv(1'b0, 1'b1, mk(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0));
    tbl[13] = mkv(1'b1, 1'b1, mk(1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1));

    // Held in reset with random enables.
    for (int i = 0; i < 4; i++) begin
      pix_ce = 1'($urandom_range(0, 1));
      en = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("reset_hold", get_act(), rst_val);
    end
    rst_n = 1'b1;

    // Vector table from the release point.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].ce, tbl[i].en);
      check("vector", get_act(), tbl[i].exp);
    end

    // Random pixel-enable / run-enable traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) != 0));
    end

    // Two full frames at full rate from the origin.
    step(1'b1, 1'b0);
    nfs = 0; nls = 0; nde = 0; nvs = 0; nhs = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step(1'b1, 1'b1);
      nfs += int'(frame_start_o);
      nls += int'(line_start_o);
      nde += int'(de_o);
      nvs += int'(vsync_o == VSP);
      nhs += int'(hsync_o == HSP);
    end
    check_int("frame_starts", nfs, 2);
    check_int("line_starts", nls, 2 * VT);
    check_int("de_cycles", nde, 2 * HA * VA);
    check_int("vsync_cycles", nvs, 2 * HT * VS);
    check_int("hsync_cycles", nhs, 2 * VT * HS);

    // Half-rate pixel enable: strobes stay one clk, period doubles.
    step(1'b1, 1'b0);
    nls = 0; nfs = 0; nhs = 0;
    for (int i = 0; i < 4 * HT * VT; i++) begin
      step(1'(i % 2 == 0), 1'b1);
      nls += int'(line_start_o);
      nfs += int'(frame_start_o);
      nhs += int'(hsync_o == HSP);
    end
    check_int("half_line_starts", nls, 2 * VT);
    check_int("half_frame_starts", nfs, 2);
    check_int("half_hsync_cycles", nhs, 2 * VT * 2 * HS);

    // en dropped mid-line for three clocks, then clean restart.
    guard = 0;
    while (!(mh == 3 && mv == 2) && guard < 200) begin
      step(1'b1, 1'b1);
      guard++;
    end
    check_int("reach_mid_line", guard < 200 ? 1 : 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check("en_low", get_act(), rst_val);
    end
    step(1'b1, 1'b1);
    check("en_restart", get_act(), mk(~HSP, ~VSP, 1'b1, 0, 0, 1'b1, 1'b1));
    step(1'b1, 1'b1);

    // Asynchronous reset while vsync is active.
    guard = 0;
    while (!(mh == 6 && mv == 4) && guard < 200) begin
      step(1'b1, 1'b1);
      guard++;
    end
    check_int("reach_vsync", guard < 200 ? 1 : 0, 1);
    check_int("vsync_active_before_rst", int'(vsync_o == VSP), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", get_act(), rst_val);
    mexp = rst_val;
    mh = 0;
    mv = 0;
    @(posedge clk);
    #1;
    check("reset_edge", get_act(), rst_val);
    rst_n = 1'b1;
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("post_reset_origin", get_act(), mk(~HSP, ~VSP, 1'b1, 0, 0, 1'b1, 1'b1));
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
